// File: rtl/ex_stage.sv
// ex_stage: 16-bit execute stage with a single-cycle ALU and a 16-iteration shift-add multiplier.
module ex_stage (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        InValid,
   input  logic        IRegWrite,
   input  logic        IALUSrc,
   input  logic        IBranch,
   input  logic        IMemWrite,
   input  logic        IMemRead,
   input  logic        IRegStore,
   input  logic [2:0]  IALUOP,
   input  logic [15:0] I1stArg,
   input  logic [15:0] I2ndArg,
   input  logic [15:0] IImm,
   input  logic [15:0] IRd,
   input  logic        Flush,
   output logic        Stall,
   output logic        OValid,
   output logic        ORegWrite,
   output logic        OMemWrite,
   output logic        OMemRead,
   output logic        ORegStore,
   output logic        OBranchTaken,
   output logic [15:0] OALUResult,
   output logic [15:0] OStoreData,
   output logic [15:0] ORd
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
   state_t state, nxt;
   logic [3:0] cnt;
   logic [15:0] mcand, mplier, prod, op_b, alu, h_sd, h_rd;
   logic h_rw, h_mw, h_mr, h_rs, h_bt, is_mul, start, taken, load_alu;
   assign op_b = IALUSrc ? IImm : I2ndArg;
   assign is_mul = IALUOP == 3'b111;
   assign start = state == IDLE && InValid && is_mul && !Flush;
   assign load_alu = state == IDLE && InValid && !is_mul && !Flush;
   assign taken = IBranch && (I1stArg == I2ndArg);
   always_comb
      alu = IALUOP == 3'b000 ? I1stArg + op_b :
            IALUOP == 3'b001 ? I1stArg - op_b :
            IALUOP == 3'b010 ? I1stArg & op_b :
            IALUOP == 3'b011 ? I1stArg | op_b :
            IALUOP == 3'b100 ? I1stArg ^ op_b :
            IALUOP == 3'b101 ? I1stArg << op_b[3:0] :
            IALUOP == 3'b110 ? {15'b0, $signed(I1stArg) < $signed(op_b)} : 16'h0000;
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = Flush ? IDLE :
            state == IDLE ? (start ? MUL : IDLE) :
            state == MUL ? (cnt == 4'hf ? DONE : MUL) : IDLE;
   always_comb Stall = Reset && !Flush && (start || state == MUL);
   // operands and control fields are captured at issue so the mul completes even if ID/EX changes
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) begin
         {mcand, mplier, prod, h_sd, h_rd, cnt} <= '0;
         {h_rw, h_mw, h_mr, h_rs, h_bt} <= '0;
      end else if (start) begin
         mcand <= I1stArg;
         mplier <= op_b;
         prod <= 16'h0000;
         cnt <= 4'h0;
         h_sd <= I2ndArg;
         h_rd <= IRd;
         {h_rw, h_mw, h_mr, h_rs, h_bt} <= {IRegWrite, IMemWrite, IMemRead, IRegStore, taken};
      end else if (state == MUL && !Flush) begin
         prod <= prod + (mplier[0] ? mcand : 16'h0000);
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt + 4'h1;
      end
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) begin
         {OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken} <= '0;
         {OALUResult, OStoreData, ORd} <= '0;
      end else if (!Flush && state == DONE) begin
         {OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken} <= {1'b1, h_rw, h_mw, h_mr, h_rs, h_bt};
         {OALUResult, OStoreData, ORd} <= {prod, h_sd, h_rd};
      end else if (load_alu) begin
         {OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken} <= {1'b1, IRegWrite, IMemWrite, IMemRead, IRegStore, taken};
         {OALUResult, OStoreData, ORd} <= {alu, I2ndArg, IRd};
      end else
         {OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken} <= '0;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
   logic CLK = 1'b0, Reset = 1'b0, InValid = 1'b0, Flush = 1'b0;
   logic IRegWrite = 1'b0, IALUSrc = 1'b0, IBranch = 1'b0, IMemWrite = 1'b0, IMemRead = 1'b0, IRegStore = 1'b0;
   logic [2:0] IALUOP = 3'd0;
   logic [15:0] I1stArg = '0, I2ndArg = '0, IImm = '0, IRd = '0;
   logic Stall, OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken;
   logic [15:0] OALUResult, OStoreData, ORd;
   int n_vec = 0, n_err = 0;

   ex_stage dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .IRegWrite(IRegWrite), .IALUSrc(IALUSrc),
      .IBranch(IBranch), .IMemWrite(IMemWrite), .IMemRead(IMemRead), .IRegStore(IRegStore),
      .IALUOP(IALUOP), .I1stArg(I1stArg), .I2ndArg(I2ndArg), .IImm(IImm), .IRd(IRd),
      .Flush(Flush), .Stall(Stall), .OValid(OValid), .ORegWrite(ORegWrite), .OMemWrite(OMemWrite),
      .OMemRead(OMemRead), .ORegStore(ORegStore), .OBranchTaken(OBranchTaken),
      .OALUResult(OALUResult), .OStoreData(OStoreData), .ORd(ORd)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         3'd0: return 16'((int'(a) + int'(b)) % 65536);
         3'd1: return 16'((int'(a) - int'(b) + 65536) % 65536);
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return 16'((int'(a) * (2 ** int'(b % 16))) % 65536);
         3'd6: return (sa < sb) ? 16'd1 : 16'd0;
         default: return 16'((longint'(a) * longint'(b)) % 65536);
      endcase
   endfunction

   function automatic logic [15:0] ctl_word();
      return {10'b0, OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken};
   endfunction

   task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic src, input logic [15:0] rd, input logic [4:0] ctl);
      {InValid, IALUOP, I1stArg, I2ndArg, IImm, IALUSrc, IRd} = {v, op, a, b, imm, src, rd};
      {IRegWrite, IBranch, IMemWrite, IMemRead, IRegStore} = ctl;
   endtask

   task automatic edge_tick();
      @(posedge CLK);
      #1;
   endtask

   // Applies the currently driven instruction and checks Stall and the resulting outputs.
   task automatic run(input string tag);
      logic [15:0] bb, res, ctl;
      bb = IALUSrc ? IImm : I2ndArg;
      res = ref_alu(IALUOP, I1stArg, bb);
      ctl = {10'b0, 1'b1, IRegWrite, IMemWrite, IMemRead, IRegStore, IBranch && (I1stArg == I2ndArg)};
      #1;
      if (!InValid) begin
         chk({tag, "_stall"}, 16'(Stall), 16'd0);
         edge_tick();
         chk({tag, "_bubble"}, ctl_word(), 16'd0);
         return;
      end
      if (IALUOP == 3'b111)
         for (int i = 0; i < 17; i++) begin
            chk({tag, "_mulstall"}, 16'(Stall), 16'd1);
            edge_tick();
            chk({tag, "_mulbubble"}, ctl_word(), 16'd0);
         end
      chk({tag, "_stall"}, 16'(Stall), 16'd0);
      edge_tick();
      chk({tag, "_ctl"}, ctl_word(), ctl);
      chk({tag, "_res"}, OALUResult, res);
      chk({tag, "_sd"}, OStoreData, I2ndArg);
      chk({tag, "_rd"}, ORd, IRd);
   endtask

   initial begin
      drive(1'b1, 3'b111, 16'h1234, 16'h5678, 16'h0, 1'b0, 16'h9, 5'b11111);
      #2;
      chk("rst_ctl", ctl_word(), 16'd0);
      chk("rst_res", OALUResult, 16'h0000);
      chk("rst_sd", OStoreData, 16'h0000);
      chk("rst_rd", ORd, 16'h0000);
      chk("rst_stall", 16'(Stall), 16'd0);
      InValid = 1'b0;
      #10 Reset = 1'b1;
      edge_tick();
      drive(1'b1, 3'b000, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 16'h0003, 5'b10000);
      run("add");
      chk("add_const", OALUResult, 16'h8000);
      drive(1'b1, 3'b001, 16'h0003, 16'h1111, 16'h0005, 1'b1, 16'h0004, 5'b10000);
      run("subi");
      chk("subi_const", OALUResult, 16'hFFFE);
      drive(1'b1, 3'b110, 16'h0003, 16'h1111, 16'h0005, 1'b1, 16'h0004, 5'b10000);
      run("slti");
      chk("slti_const", OALUResult, 16'h0001);
      drive(1'b1, 3'b111, 16'h0123, 16'h0010, 16'h0, 1'b0, 16'h0007, 5'b10000);
      run("mul");
      chk("mul_const", OALUResult, 16'h1230);
      drive(1'b1, 3'b000, 16'h00AA, 16'h00AA, 16'h0, 1'b0, 16'h0000, 5'b01100);
      run("branch");
      chk("branch_taken", 16'(OBranchTaken), 16'd1);
      InValid = 1'b0;
      run("bubble");
      // flush on the fifth MUL cycle
      drive(1'b1, 3'b111, 16'h0123, 16'h0010, 16'h0, 1'b0, 16'h0007, 5'b10000);
      #1;
      for (int i = 0; i < 5; i++) edge_tick();
      chk("flush_pre_stall", 16'(Stall), 16'd1);
      Flush = 1'b1;
      #1;
      chk("flush_stall", 16'(Stall), 16'd0);
      edge_tick();
      chk("flush_bubble", ctl_word(), 16'd0);
      Flush = 1'b0;
      drive(1'b1, 3'b000, 16'h1000, 16'h0234, 16'h0, 1'b0, 16'h0002, 5'b10001);
      run("post_flush_add");
      // asynchronous reset in the middle of a mul
      drive(1'b1, 3'b111, 16'h00FF, 16'h0101, 16'h0, 1'b0, 16'h0005, 5'b10000);
      for (int i = 0; i < 3; i++) edge_tick();
      #2 Reset = 1'b0;
      #1;
      chk("mrst_ctl", ctl_word(), 16'd0);
      chk("mrst_res", OALUResult, 16'h0000);
      chk("mrst_sd", OStoreData, 16'h0000);
      chk("mrst_rd", ORd, 16'h0000);
      chk("mrst_stall", 16'(Stall), 16'd0);
      InValid = 1'b0;
      #1 Reset = 1'b1;
      edge_tick();
      drive(1'b1, 3'b111, 16'h00FF, 16'h0101, 16'h0, 1'b0, 16'h0005, 5'b10000);
      run("mrst_mul");
      chk("mrst_mul_const", OALUResult, 16'hFFFF);
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a, b;
         a = 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
         drive($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), a, b, 16'($urandom),
               1'($urandom), 16'($urandom), 5'($urandom));
         run("rand");
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 InValid  in  1  the ID/EX register holds a live instruction.
REQ-005 IRegWrite, IALUSrc, IBranch, IMemWrite, IMemRead, IRegStore  in  1 each  control fields from ID/EX.
REQ-006 IALUOP  in  3  ALU operation.
REQ-007 I1stArg, I2ndArg, IImm, IRd  in  16 each  operand A, operand B register value, immediate, destination tag.
REQ-008 Flush  in  1  squash the instruction currently in EX.
REQ-009 Stall  out  1  combinational; upstream SHALL hold all ID/EX inputs constant while high.
REQ-010 OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken  out  1 each  registered EX/MEM control outputs.
REQ-011 OALUResult, OStoreData, ORd  out  16 each  registered EX/MEM data outputs.

Function
REQ-012 Operand B SHALL be IImm when IALUSrc=1, else I2ndArg.
REQ-013 IALUOP encoding: 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 sll (A << B[3:0]), 110 signed slt (result 1 or 0), 111 mul (low 16 bits of A*B).
REQ-014 Add, sub and mul SHALL wrap modulo 2^16; no overflow flag.
REQ-015 Branch taken = IBranch && (I1stArg == I2ndArg); the comparison ignores IALUSrc.
REQ-016 OStoreData SHALL be I2ndArg; ORd SHALL be IRd.
REQ-017 FSM states: IDLE, MUL, DONE.
REQ-018 Non-mul op in IDLE with InValid=1: outputs load on the next edge; latency 1; Stall=0.
REQ-019 IDLE with InValid=1 and IALUOP=111:
- Stall=1 in that same cycle.
- Operands are latched and the 4-bit iteration counter is cleared.
- Next state is MUL.
REQ-020 MUL: one shift-add iteration per cycle; Stall=1; after 16 iterations (counter wraps 15->0), go to DONE.
REQ-021 DONE: Stall=0; on this edge the product and the held control fields load into the outputs with OValid=1; next state is IDLE.
REQ-022 A mul therefore occupies 18 cycles from its first IDLE cycle to output load.
REQ-023 Outputs SHALL load with a bubble on any edge where Stall=1 or InValid=0:
- OValid=0.
- ORegWrite, OMemWrite, OMemRead, ORegStore and OBranchTaken all 0.
- Data outputs don't-care.
REQ-024 Any edge with OValid=0 SHALL have all five control outputs at 0.
REQ-025 Flush=1 SHALL:
- load a bubble on that edge;
- force the FSM to IDLE from any state, aborting an in-progress mul;
- drop Stall to 0 in that cycle.
REQ-026 Flush takes priority over InValid, Stall and DONE.
REQ-027 When Flush=0, InValid falling during MUL SHALL be ignored; the latched operands complete.

Reset
REQ-028 While Reset=0, the block SHALL be held in its reset state asynchronously:
- FSM in IDLE, counter 0, internal operand and product registers 0.
- OValid, ORegWrite, OMemWrite, OMemRead, ORegStore, OBranchTaken all 0.
- OALUResult, OStoreData, ORd all 16'h0000.
- Stall=0.
REQ-029 Reset asserted mid-mul SHALL abort the mul and discard its result; the first instruction after release is processed from IDLE.

Verification
REQ-030 Add, 1 cycle: A=16'h7FFF, B=16'h0001, ALUSrc=0, op=000 -> next edge OALUResult=16'h8000, OValid=1.
REQ-031 Immediate sub and slt:
- ALUSrc=1, IImm=16'h0005, A=16'h0003, op=001 -> OALUResult=16'hFFFE.
- Same operands, op=110 -> OALUResult=16'h0001.
REQ-032 Mul stall: A=16'h0123, B=16'h0010, op=111:
- Stall high for exactly 17 cycles.
- The 18th edge gives OALUResult=16'h1230, OValid=1.
- OValid=0 on all intermediate edges.
REQ-033 Branch with bubble: IBranch=1, A=B=16'h00AA, IMemWrite=1 -> OBranchTaken=1; the following InValid=0 cycle -> all control outputs 0.
REQ-034 Flush mid-mul: Flush=1 on the 5th MUL cycle -> Stall=0 that cycle, next edge OValid=0; a subsequent add completes with latency 1.
REQ-035 Reset mid-mul: Reset=0 asynchronously during MUL -> outputs zero immediately; after release, a fresh mul gives the correct product 18 cycles later.
